// File: rtl/qdec_pkg.sv
// Shared types and the quadrature step decoder for the position counter.
// The Gray-coded phase state {A,B} advances 00->01->11->10->00 when moving up.
package qdec_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qdec_state_t;

    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_UP,
        EVT_DOWN,
        EVT_ILLEGAL
    } qdec_evt_t;

    // Position of a phase state along the up sequence, so that a step is a
    // difference of +1 or -1 modulo 4 and a difference of 2 is a double jump.
    function automatic logic [1:0] grayIndex(input qdec_state_t s);
        logic [1:0] idx;
        case (s)
            S00:     idx = 2'd0;
            S01:     idx = 2'd1;
            S11:     idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic qdec_evt_t decode(input qdec_state_t prev, input qdec_state_t curr);
        logic [1:0] delta;
        qdec_evt_t  evt;
        delta = grayIndex(curr) - grayIndex(prev);
        case (delta)
            2'd0:    evt = EVT_NONE;
            2'd1:    evt = EVT_UP;
            2'd3:    evt = EVT_DOWN;
            default: evt = EVT_ILLEGAL;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/qdec_phase_sync.sv
// Per-phase input conditioning: a 2-FF synchronizer, optionally followed by a
// stability filter when QDEC_FILTER_EN is defined. 'valid' rises once the
// output reflects the real pin level after reset, so the decoder can prime
// its previous-state register from a trustworthy sample.
module qdec_phase_sync
`ifdef QDEC_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic Clk,
    input  logic reset,
    input  logic phaseIn,
    output logic phaseOut,
    output logic valid
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] fill_q;

    // Two-stage synchronizer; fill_q marks when sync2 holds a genuine pin sample.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= phaseIn;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             settled_q, settled_d;

    // The filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        cnt_d     = '0;
        filt_d    = filt_q;
        settled_d = settled_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (fill_q[1]) begin
            settled_d = 1'b1;
        end
    end

    // Filter state register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            filt_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            settled_q <= settled_d;
        end
    end

    assign phaseOut = filt_q;
    assign valid    = settled_q;
`else
    assign phaseOut = sync2_q;
    assign valid    = fill_q[1];
`endif

endmodule

// File: rtl/quadrature_updown_decoder.sv
// Quadrature up/down decoder: synchronizes PhaseA/PhaseB, decodes Gray steps
// into Step/UpOrDown pulses, keeps a wrapping position count and a saturating
// illegal-transition count. Define QDEC_FILTER_EN to add a per-phase
// stability filter of FILTER_LEN samples behind each synchronizer.
module quadrature_updown_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int ERR_WIDTH  = 4,
    parameter int FILTER_LEN = 4
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 PhaseA,
    input  logic                 PhaseB,
    input  logic                 Clear,
    output logic [WIDTH-1:0]     Count,
    output logic                 UpOrDown,
    output logic                 Step,
    output logic                 Err,
    output logic [ERR_WIDTH-1:0] ErrCnt
);

    logic rstMeta_q;
    logic rstSync_q;

    // Reset asserts immediately but is released only on a Clk edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rstMeta_q <= 1'b1;
            rstSync_q <= 1'b1;
        end else begin
            rstMeta_q <= 1'b0;
            rstSync_q <= rstMeta_q;
        end
    end

    logic phaseA, phaseB, validA, validB;

`ifdef QDEC_FILTER_EN
    qdec_phase_sync #(.FILTER_LEN(FILTER_LEN)) uSyncA (
        .Clk(Clk), .reset(rstSync_q), .phaseIn(PhaseA), .phaseOut(phaseA), .valid(validA)
    );
    qdec_phase_sync #(.FILTER_LEN(FILTER_LEN)) uSyncB (
        .Clk(Clk), .reset(rstSync_q), .phaseIn(PhaseB), .phaseOut(phaseB), .valid(validB)
    );
`else
    qdec_phase_sync uSyncA (
        .Clk(Clk), .reset(rstSync_q), .phaseIn(PhaseA), .phaseOut(phaseA), .valid(validA)
    );
    qdec_phase_sync uSyncB (
        .Clk(Clk), .reset(rstSync_q), .phaseIn(PhaseB), .phaseOut(phaseB), .valid(validB)
    );

    // FILTER_LEN only shapes the filtered build; this empty guard keeps it referenced here.
    if (FILTER_LEN < 1) begin : gFilterLenUnused
    end
`endif

    qdec_state_t          curr;
    qdec_state_t          prev_q, prev_d;
    qdec_evt_t            evt;
    logic                 primed_q, primed_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [ERR_WIDTH-1:0] errCnt_q, errCnt_d;
    logic                 upOrDown_q, upOrDown_d;
    logic                 step_q, step_d;
    logic                 err_q, err_d;

    assign curr = qdec_state_t'({phaseA, phaseB});

    // Prime on the first valid sample, then turn each state change into an event.
    always_comb begin
        prev_d     = prev_q;
        primed_d   = primed_q;
        count_d    = count_q;
        errCnt_d   = errCnt_q;
        upOrDown_d = upOrDown_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        evt        = EVT_NONE;
        if (!primed_q) begin
            if (validA && validB) begin
                prev_d   = curr;
                primed_d = 1'b1;
            end
        end else begin
            evt    = decode(prev_q, curr);
            prev_d = curr;
            case (evt)
                EVT_UP: begin
                    count_d    = count_q + WIDTH'(1);
                    upOrDown_d = 1'b1;
                    step_d     = 1'b1;
                end
                EVT_DOWN: begin
                    count_d    = count_q - WIDTH'(1);
                    upOrDown_d = 1'b0;
                    step_d     = 1'b1;
                end
                EVT_ILLEGAL: begin
                    err_d = 1'b1;
                    if (errCnt_q != '1) begin
                        errCnt_d = errCnt_q + ERR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
        if (Clear) begin
            count_d  = '0;
            errCnt_d = '0;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge Clk or posedge rstSync_q) begin
        if (rstSync_q) begin
            prev_q     <= S00;
            primed_q   <= 1'b0;
            count_q    <= '0;
            errCnt_q   <= '0;
            upOrDown_q <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            count_q    <= count_d;
            errCnt_q   <= errCnt_d;
            upOrDown_q <= upOrDown_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign Count    = count_q;
    assign UpOrDown = upOrDown_q;
    assign Step     = step_q;
    assign Err      = err_q;
    assign ErrCnt   = errCnt_q;

endmodule

// File: tb/tb_quadrature_updown_decoder.sv
// Bench for quadrature_updown_decoder. A position/error model driven by the
// pin levels seen a fixed number of edges earlier is compared every cycle,
// and directed steps pin it with hand-computed values. The QDEC_FILTER_EN
// build also runs a glitch-rejection scenario.
module tb_quadrature_updown_decoder;

    localparam int WIDTH      = 5;
    localparam int ERR_WIDTH  = 4;
    localparam int FILTER_LEN = 4;
    localparam int MOD        = 1 << WIDTH;
    localparam int ERR_MAX    = (1 << ERR_WIDTH) - 1;
`ifdef QDEC_FILTER_EN
    localparam int DLY = 2 + FILTER_LEN;
`else
    localparam int DLY = 2;
`endif

    logic                 Clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 PhaseA = 1'b1;
    logic                 PhaseB = 1'b1;
    logic                 Clear = 1'b0;
    logic [WIDTH-1:0]     Count;
    logic                 UpOrDown;
    logic                 Step;
    logic                 Err;
    logic [ERR_WIDTH-1:0] ErrCnt;

    int total = 0;
    int bad = 0;
    int stepSeen = 0;
    int errSeen = 0;
    bit modelOn = 1'b1;
    int expCount = 0;
    int expErrCnt = 0;
    int expUp = 0;
    int expStep = 0;
    int expErr = 0;
    logic [1:0] hist [0:DLY];
    logic [1:0] ph = 2'b11;

    always #5 Clk = ~Clk;

    quadrature_updown_decoder #(
        .WIDTH(WIDTH), .ERR_WIDTH(ERR_WIDTH), .FILTER_LEN(FILTER_LEN)
    ) dut (
        .Clk(Clk), .reset(reset), .PhaseA(PhaseA), .PhaseB(PhaseB), .Clear(Clear),
        .Count(Count), .UpOrDown(UpOrDown), .Step(Step), .Err(Err), .ErrCnt(ErrCnt)
    );

    function automatic int gpos(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] nextUp(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input int hold);
        {PhaseA, PhaseB} = s;
        ph = s;
        repeat (hold) @(negedge Clk);
    endtask

    // Model: the pins seen DLY edges ago versus the edge before decide the event.
    always @(posedge Clk) begin
        logic [1:0] cur;
        logic [1:0] prv;
        int d;
        #1;
        if (Step) stepSeen++;
        if (Err) errSeen++;
        if (reset || !modelOn) begin
            if (reset) begin
                expCount  = 0;
                expErrCnt = 0;
                expUp     = 0;
            end
            expStep = 0;
            expErr  = 0;
            for (int i = 0; i <= DLY; i++) hist[i] = {PhaseA, PhaseB};
        end else begin
            cur = hist[DLY-1];
            prv = hist[DLY];
            d = (gpos(cur) - gpos(prv) + 4) % 4;
            expStep = (d == 1 || d == 3) ? 1 : 0;
            expErr  = (d == 2) ? 1 : 0;
            if (d == 1) begin
                expCount = (expCount + 1) % MOD;
                expUp = 1;
            end else if (d == 3) begin
                expCount = (expCount + MOD - 1) % MOD;
                expUp = 0;
            end else if (d == 2 && expErrCnt < ERR_MAX) begin
                expErrCnt++;
            end
            if (Clear) begin
                expCount  = 0;
                expErrCnt = 0;
            end
            for (int i = DLY; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {PhaseA, PhaseB};
        end
        if (modelOn) begin
            checkOutput("model_Count", Count, expCount);
            checkOutput("model_UpOrDown", UpOrDown, expUp);
            checkOutput("model_Step", Step, expStep);
            checkOutput("model_Err", Err, expErr);
            checkOutput("model_ErrCnt", ErrCnt, expErrCnt);
        end
    end

    initial begin
        #1 reset = 1'b1;

        // Priming: reset with both phases high, then hold them.
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        repeat (20) @(negedge Clk);
        checkOutput("prime_count", Count, 0);
        checkOutput("prime_steps", stepSeen, 0);
        checkOutput("prime_errs", errSeen, 0);

        // Restart from 00 for the counting run.
        reset = 1'b1;
        applyStimulus(2'b00, 3);
        reset = 1'b0;
        repeat (20) @(negedge Clk);

        // 32 up steps wrap the 5-bit count back to 0.
        stepSeen = 0;
        for (int i = 1; i <= 31; i++) applyStimulus(nextUp(ph), 4);
        repeat (DLY + 1) @(negedge Clk);
        checkOutput("up_count_31", Count, 31);
        applyStimulus(nextUp(ph), 4);
        repeat (DLY + 1) @(negedge Clk);
        checkOutput("up_wrap_count", Count, 0);
        checkOutput("up_dir", UpOrDown, 1);
        checkOutput("up_step_pulses", stepSeen, 32);

        // One down step 00->10 wraps to 31 with the pulse on the last latency edge.
        {PhaseA, PhaseB} = 2'b10;
        ph = 2'b10;
        for (int k = 0; k <= DLY; k++) begin
            @(posedge Clk);
            #1 checkOutput("down_step_latency", Step, (k == DLY) ? 1 : 0);
        end
        checkOutput("down_wrap_count", Count, 31);
        checkOutput("down_dir", UpOrDown, 0);
        @(negedge Clk);
        repeat (2) @(negedge Clk);

        // Back up to 00 (count 0), then a double jump 00->11.
        applyStimulus(2'b00, DLY + 2);
        checkOutput("back_to_zero", Count, 0);
        {PhaseA, PhaseB} = 2'b11;
        ph = 2'b11;
        for (int k = 0; k <= DLY; k++) begin
            @(posedge Clk);
            #1 checkOutput("illegal_err_latency", Err, (k == DLY) ? 1 : 0);
        end
        checkOutput("illegal_errcnt_1", ErrCnt, 1);
        checkOutput("illegal_count_held", Count, 0);
        checkOutput("illegal_no_step", Step, 0);
        @(negedge Clk);
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 16; i++) applyStimulus(~ph, 4);
        repeat (DLY + 1) @(negedge Clk);
        checkOutput("errcnt_saturated", ErrCnt, 15);
        checkOutput("errcnt_count_held", Count, 0);

        // Clear lands on the same edge as an up step 11->10.
        {PhaseA, PhaseB} = 2'b10;
        ph = 2'b10;
        repeat (DLY) @(negedge Clk);
        Clear = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("clear_step_pulse", Step, 1);
        checkOutput("clear_count", Count, 0);
        checkOutput("clear_errcnt", ErrCnt, 0);
        checkOutput("clear_dir", UpOrDown, 1);
        @(negedge Clk);
        Clear = 1'b0;
        repeat (3) @(negedge Clk);

        // Seven up steps, then an asynchronous reset in mid-cycle.
        for (int i = 0; i < 7; i++) applyStimulus(nextUp(ph), 4);
        repeat (DLY + 1) @(negedge Clk);
        checkOutput("pre_reset_count", Count, 7);
        @(posedge Clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_reset_count", Count, 0);
        checkOutput("async_reset_dir", UpOrDown, 0);
        checkOutput("async_reset_step", Step, 0);
        checkOutput("async_reset_err", Err, 0);
        checkOutput("async_reset_errcnt", ErrCnt, 0);
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        repeat (20) @(negedge Clk);
        errSeen = 0;
        applyStimulus(nextUp(ph), DLY + 2);
        checkOutput("reprime_count", Count, 1);
        checkOutput("reprime_errs", errSeen, 0);

`ifdef QDEC_FILTER_EN
        // A 2-cycle glitch on PhaseA must not reach the decoder.
        modelOn = 1'b0;
        stepSeen = 0;
        errSeen = 0;
        {PhaseA, PhaseB} = ph ^ 2'b10;
        repeat (2) @(negedge Clk);
        {PhaseA, PhaseB} = ph;
        repeat (12) @(negedge Clk);
        checkOutput("glitch_no_step", stepSeen, 0);
        checkOutput("glitch_no_err", errSeen, 0);
        checkOutput("glitch_count", Count, 1);
        modelOn = 1'b1;
        repeat (2) @(negedge Clk);

        // A stable up step shows its pulse on the seventh edge.
        {PhaseA, PhaseB} = nextUp(ph);
        ph = nextUp(ph);
        for (int k = 0; k <= DLY; k++) begin
            @(posedge Clk);
            #1 checkOutput("filter_step_latency", Step, (k == DLY) ? 1 : 0);
        end
        checkOutput("filter_count", Count, 2);
        @(negedge Clk);
        repeat (4) @(negedge Clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
